// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared constants, FSM states and pc_in source select for the PC sequencer
package proc_pkg;

  localparam int              PC_W       = 32;
  localparam logic [PC_W-1:0] RESET_VEC  = '0;
  localparam int              IMEM_DEPTH = 1024;
  localparam logic [PC_W-1:0] TRAP_VEC   = 32'd1;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    DRAIN,
    HALTED
  } state_e;

  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_ZERO,
    SEL_VEC,
    SEL_PROX,
    SEL_TARGET
  } pc_sel_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - instruction-memory fetch port: req/addr toward memory, ack back
interface pc_sequencer_if;
  import proc_pkg::*;

  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;

  modport master (output imem_req, output imem_addr, input imem_ack);
  modport slave  (input imem_req, input imem_addr, output imem_ack);

endinterface

// File: rtl/pc_redirect_mux.sv
// rtl/pc_redirect_mux.sv - combinational pc_in/jump_stop/trap select for the PC register
// PC_BOUNDS_EN: branch targets >= IMEM_DEPTH are replaced by TRAP_VEC and flagged on trap_o.
module pc_redirect_mux
  import proc_pkg::*;
(
  input  pc_sel_e         sel_i,
  input  logic [PC_W-1:0] pc_at_i,
  input  logic [PC_W-1:0] pc_prox_i,
  input  logic [PC_W-1:0] br_target_i,
  output logic [PC_W-1:0] pc_in_o,
  output logic            jump_stop_o,
  output logic            trap_o
);

  logic [PC_W-1:0] target;
  logic            out_of_range;

`ifdef PC_BOUNDS_EN
  assign out_of_range = (br_target_i >= PC_W'(IMEM_DEPTH));
  assign target       = out_of_range ? TRAP_VEC : br_target_i;
`else
  assign out_of_range = 1'b0;
  assign target       = br_target_i;
`endif

  always_comb begin
    pc_in_o     = pc_at_i;
    jump_stop_o = 1'b1;
    trap_o      = 1'b0;
    case (sel_i)
      SEL_ZERO: pc_in_o = '0;
      SEL_VEC: begin
        pc_in_o     = RESET_VEC;
        jump_stop_o = 1'b0;
      end
      SEL_PROX: begin
        pc_in_o     = pc_prox_i;
        jump_stop_o = 1'b0;
      end
      SEL_TARGET: begin
        pc_in_o     = target;
        jump_stop_o = 1'b0;
        trap_o      = out_of_range;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - BOOT/RUN/DRAIN/HALTED sequencer driving the PC register and fetch port
// Optional macro PC_BOUNDS_EN enables the out-of-range target trap (inside pc_redirect_mux).
module pc_sequencer
  import proc_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic [PC_W-1:0] pc_at,
  input  logic [PC_W-1:0] pc_prox,
  input  logic            br_valid,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  input  logic            stall,
  input  logic            halt_req,
  input  logic            resume,
  pc_sequencer_if.master  imem,
  output logic [PC_W-1:0] pc_in,
  output logic            jump_stop,
  output logic            pc_halt,
  output logic            pc_rst,
  output logic            flush,
  output logic            halted,
  output logic            trap
);

  state_e          state_q, state_d;
  pc_sel_e         sel;
  logic            boot_q;
  logic            halt_pend_q, halt_pend_d;
  logic            flush_q, flush_d;
  logic            trap_q, trap_d;
  logic [PC_W-1:0] imem_addr_q, imem_addr_d, npc;
  logic            addr_upd, req, redirect;

  assign redirect = br_valid & br_taken;

  pc_redirect_mux u_mux (
    .sel_i       (sel),
    .pc_at_i     (pc_at),
    .pc_prox_i   (pc_prox),
    .br_target_i (br_target),
    .pc_in_o     (pc_in),
    .jump_stop_o (jump_stop),
    .trap_o      (trap_d)
  );

  // Value pc_at will hold next cycle; the fetch address register tracks it.
  assign npc         = jump_stop ? pc_at : pc_in;
  assign imem_addr_d = addr_upd ? npc : imem_addr_q;

  always_comb begin
    state_d     = state_q;
    sel         = SEL_HOLD;
    req         = 1'b0;
    pc_rst      = 1'b0;
    flush_d     = 1'b0;
    addr_upd    = 1'b0;
    halt_pend_d = halt_pend_q;
    unique case (state_q)
      BOOT: begin
        pc_rst  = 1'b1;
        sel     = SEL_ZERO;
        state_d = RUN;
      end
      RUN: begin
        if (boot_q) begin
          // PC register comes out of its own reset at 0; load the boot vector before fetching.
          sel      = SEL_VEC;
          addr_upd = 1'b1;
        end else begin
          req      = 1'b1;
          addr_upd = 1'b1;
          if (redirect) begin
            sel     = SEL_TARGET;
            flush_d = 1'b1;
            if (!imem.imem_ack) begin
              state_d     = DRAIN;
              addr_upd    = 1'b0;
              halt_pend_d = halt_req;
            end else if (halt_req) begin
              state_d = HALTED;
            end
          end else if (stall || !imem.imem_ack) begin
            sel = SEL_HOLD;
          end else begin
            sel = SEL_PROX;
            if (halt_req) state_d = HALTED;
          end
        end
      end
      DRAIN: begin
        req = 1'b1;
        if (redirect) sel = SEL_TARGET;
        if (imem.imem_ack) begin
          flush_d     = 1'b1;
          addr_upd    = 1'b1;
          halt_pend_d = 1'b0;
          state_d     = halt_pend_q ? HALTED : RUN;
        end
      end
      HALTED: begin
        addr_upd = 1'b1;
        if (resume) state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= BOOT;
      boot_q      <= 1'b0;
      halt_pend_q <= 1'b0;
      imem_addr_q <= '0;
      flush_q     <= 1'b0;
      trap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      boot_q      <= (state_q == BOOT);
      halt_pend_q <= halt_pend_d;
      imem_addr_q <= imem_addr_d;
      flush_q     <= flush_d;
      trap_q      <= trap_d;
    end
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = imem_addr_q;
  assign pc_halt        = (state_q == HALTED);
  assign halted         = (state_q == HALTED);
  assign flush          = flush_q;
  assign trap           = trap_q;

endmodule
